// File: rtl/dh_mod_reduce_if.sv
// Start/done handshake bundle for the modular reduction stage.
// master drives the request side, slave (the reducer) drives results.
interface dh_mod_reduce_if #(
    parameter int DW = 64,
    parameter int MW = 32
);
    logic          start;
    logic [DW-1:0] value;
    logic [MW-1:0] modulus;
    logic [MW-1:0] remainder;
    logic          done;
    logic          busy;
    logic          err;

    modport master (
        output start, value, modulus,
        input  remainder, done, busy, err
    );

    modport slave (
        input  start, value, modulus,
        output remainder, done, busy, err
    );
endinterface

// File: rtl/dh_mod_reduce.sv
// Bit-serial restoring reduction: remainder = value mod modulus.
// Define DH_MOD_RADIX4_EN to retire two dividend bits per cycle.
module dh_mod_reduce #(
    parameter int DW = 64,
    parameter int MW = 32
) (
    input  logic             clk,
    input  logic             rst,
    dh_mod_reduce_if.slave   bus
);

`ifdef DH_MOD_RADIX4_EN
    localparam int ST = 2;
`else
    localparam int ST = 1;
`endif

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT0 = CW'(DW / ST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [MW-1:0] m_q, m_d;
    logic [MW-1:0] r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] rem_q, rem_d;
    logic          err_q, err_d;
    logic [MW-1:0] r_nx;
    logic [DW-1:0] sh_nx;

    // One restoring step. r < m on entry, so the shifted
    // value fits MW+1 bits and the result fits MW bits.
    function automatic logic [MW-1:0] step(
        input logic [MW-1:0] r,
        input logic          b,
        input logic [MW-1:0] m
    );
        logic [MW:0] t;
        t = {r, b};
        if (t >= {1'b0, m})
            step = MW'(t - {1'b0, m});
        else
            step = t[MW-1:0];
    endfunction

    // Per-cycle partial remainder and dividend shift.
    always_comb begin
`ifdef DH_MOD_RADIX4_EN
        r_nx  = step(step(r_q, sh_q[DW-1], m_q), sh_q[DW-2], m_q);
`else
        r_nx  = step(r_q, sh_q[DW-1], m_q);
`endif
        sh_nx = {sh_q[DW-ST-1:0], {ST{1'b0}}};
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        m_d     = m_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.modulus != '0) begin
                        sh_d    = bus.value;
                        m_d     = bus.modulus;
                        r_d     = '0;
                        cnt_d   = CNT0;
                        state_d = S_CALC;
                    end else begin
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end else begin
                    sh_d  = sh_nx;
                    r_d   = r_nx;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rem_d   = r_nx;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            m_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            m_q     <= m_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.remainder = rem_q;
    assign bus.err       = err_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_CALC);

endmodule

// File: tb/tb_dh_mod_reduce.sv
// Randomized bench for dh_mod_reduce against a plain modulo model.
// Build with DH_MOD_RADIX4_EN to match a radix-4 design build.
module tb_dh_mod_reduce;
    localparam int DW = 64;
    localparam int MW = 32;
`ifdef DH_MOD_RADIX4_EN
    localparam int LAT = DW / 2 + 1;
`else
    localparam int LAT = DW + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dh_mod_reduce_if #(.DW(DW), .MW(MW)) bus ();

    dh_mod_reduce #(.DW(DW), .MW(MW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [63:0] v, input logic [31:0] m,
                       input string tag);
        logic [63:0] want;
        int          n;
        bit          seen;
        want = (m == 0) ? 64'd0 : v % {32'd0, m};
        @(negedge clk);
        bus.value   = v;
        bus.modulus = m;
        bus.start   = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LAT + 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                bus.value   = {$urandom, $urandom};
                bus.modulus = $urandom;
                if (m != 0) check({tag, "/busy"}, 64'(bus.busy), 64'd1);
            end
            seen = bus.done;
        end
        check({tag, "/lat"}, 64'(n), (m == 0) ? 64'd1 : 64'(LAT));
        check({tag, "/rem"}, 64'(bus.remainder), want);
        check({tag, "/err"}, 64'(bus.err), (m == 0) ? 64'd1 : 64'd0);
        check({tag, "/busy0"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "/hold"}, 64'(bus.done), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "/drop"}, 64'(bus.done), 64'd0);
        check({tag, "/errclr"}, 64'(bus.err), 64'd0);
    endtask

    initial begin
        logic [63:0] rv;
        logic [31:0] rm;
        bus.start   = 1'b0;
        bus.value   = '0;
        bus.modulus = '0;
        #12;
        check("rst/rem", 64'(bus.remainder), 64'd0);
        check("rst/done", 64'(bus.done), 64'd0);
        check("rst/busy", 64'(bus.busy), 64'd0);
        check("rst/err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run(64'd1000, 32'd23, "k1000");
        run(64'd1220703125, 32'd23, "p5_13");
        run(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, "allone");
        run(64'd5, 32'hFFFF_FFFB, "small");
        run(64'd77, 32'd0, "mod0");
        run(64'h1234_5678_9ABC_DEF0, 32'd1, "mod1");
        run(64'd0, 32'd99, "val0");

        for (int i = 0; i < 16; i++) begin
            rv = {$urandom, $urandom};
            rm = $urandom;
            if (i % 4 == 1) rm = $urandom_range(1, 255);
            if (i % 4 == 2) rv = 64'($urandom) >> (i % 8);
            if (rm == 0) rm = 32'd3;
            run(rv, rm, $sformatf("rnd%0d", i));
        end

        run(64'd1000, 32'd23, "pre_abort");
        @(negedge clk);
        bus.value   = 64'hDEAD_BEEF_CAFE_F00D;
        bus.modulus = 32'd1234567;
        bus.start   = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort/busy", 64'(bus.busy), 64'd0);
        check("abort/done", 64'(bus.done), 64'd0);
        check("abort/rem", 64'(bus.remainder), 64'd11);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort/idle", 64'(bus.done), 64'd0);
            check("abort/keep", 64'(bus.remainder), 64'd11);
        end
        run(64'd100, 32'd7, "post_abort");

        @(negedge clk);
        bus.value   = 64'hFEDC_BA98_7654_3210;
        bus.modulus = 32'd1000003;
        bus.start   = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        check("arst/busy_pre", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst/rem", 64'(bus.remainder), 64'd0);
        check("arst/done", 64'(bus.done), 64'd0);
        check("arst/busy", 64'(bus.busy), 64'd0);
        check("arst/err", 64'(bus.err), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        run(64'd1000, 32'd23, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
